// File: rtl/pcie_msi_irq_ctrl.sv
// -----------------------------------------------------------------------------
// pcie_msi_irq_ctrl
//
// Purpose:
//   Turns interrupt requests from the core into MSI requests on the PCIe hard
//   IP's cfg_interrupt_msi_* interface (function 0). Requests are coalesced
//   into a per-vector pending bitmap. Eligible vectors are served round-robin,
//   with one MSI in flight at a time. Each MSI is closed by
//   cfg_interrupt_msi_sent or cfg_interrupt_msi_fail.
//
// Build option:
//   PCIE_MSI_FAIL_RETRY_EN - when defined, a failed MSI re-sets its pending
//   bit and the controller backs off for RETRY_DELAY cycles before it issues
//   anything else. When undefined, a failed MSI is dropped and RETRY_DELAY /
//   RETRY_CNT_WIDTH have no effect.
//
// Ports:
//   clk, rst                        PCIe user clock, async active-high reset
//   s_axis_irq_*                    request stream (index/valid/ready)
//   cfg_interrupt_msi_enable[0]     MSI enabled for function 0
//   cfg_interrupt_msi_mmenable[2:0] log2 of the number of enabled vectors
//   cfg_interrupt_msi_int           one-hot MSI request, one-cycle pulse
//   cfg_interrupt_msi_sent/fail     completion status from the hard IP
//   other cfg_interrupt_msi_*       constant tie-offs
//   stat_irq_sent / stat_irq_fail   one-cycle event pulses
// -----------------------------------------------------------------------------
module pcie_msi_irq_ctrl #(
  parameter int IRQ_INDEX_WIDTH = 5,
  parameter int RETRY_DELAY     = 64,
  parameter int RETRY_CNT_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IRQ_INDEX_WIDTH-1:0] s_axis_irq_index,
  input  logic                       s_axis_irq_valid,
  output logic                       s_axis_irq_ready,
  input  logic [3:0]                 cfg_interrupt_msi_enable,
  input  logic [11:0]                cfg_interrupt_msi_mmenable,
  output logic [31:0]                cfg_interrupt_msi_int,
  input  logic                       cfg_interrupt_msi_sent,
  input  logic                       cfg_interrupt_msi_fail,
  output logic [3:0]                 cfg_interrupt_msi_select,
  output logic [31:0]                cfg_interrupt_msi_pending_status,
  output logic                       cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0]                 cfg_interrupt_msi_pending_status_function_num,
  output logic [2:0]                 cfg_interrupt_msi_attr,
  output logic                       cfg_interrupt_msi_tph_present,
  output logic [1:0]                 cfg_interrupt_msi_tph_type,
  output logic [8:0]                 cfg_interrupt_msi_tph_st_tag,
  output logic [3:0]                 cfg_interrupt_msi_function_number,
  output logic                       stat_irq_sent,
  output logic                       stat_irq_fail
);

  localparam int NV = 2 ** IRQ_INDEX_WIDTH;

`ifdef PCIE_MSI_FAIL_RETRY_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_BACKOFF = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;
`endif

  state_t                     state_q, state_d;
  logic [NV-1:0]              pending_q, pending_d;
  logic [NV-1:0]              mask_q, mask_d;
  logic [IRQ_INDEX_WIDTH-1:0] rr_q, rr_d;
  logic                       granted_q, granted_d;
  logic [31:0]                msi_int_q, msi_int_d;
  logic                       stat_sent_q, stat_sent_d;
  logic                       stat_fail_q, stat_fail_d;
  logic                       ready_q;

`ifdef PCIE_MSI_FAIL_RETRY_EN
  logic [RETRY_CNT_WIDTH-1:0] cnt_q, cnt_d;
`else
  logic [RETRY_CNT_WIDTH-1:0] unused_retry_s;
  assign unused_retry_s = RETRY_CNT_WIDTH'(RETRY_DELAY);
`endif

  logic                       unused_cfg_s;
  logic [31:0]                mask32_s;
  logic [NV-1:0]              eligible_s;
  logic [NV-1:0]              set_s;
  logic [NV-1:0]              clr_s;
  logic [IRQ_INDEX_WIDTH-1:0] start_s;
  logic [IRQ_INDEX_WIDTH-1:0] pick_s;
  logic                       found_s;
  logic                       issue_ok_s;
  logic                       do_issue_s;
  logic                       accept_s;

  assign unused_cfg_s = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

  assign accept_s   = s_axis_irq_valid & ready_q;
  assign eligible_s = pending_q & mask_q;
  assign issue_ok_s = cfg_interrupt_msi_enable[0] & found_s;

  // Translate multiple-message enable into a mask of enabled vectors (>=5 means all 32).
  always_comb begin
    mask32_s = 32'h0000_0000;
    if (cfg_interrupt_msi_mmenable[2:0] >= 3'd5) begin
      mask32_s = 32'hFFFF_FFFF;
    end else begin
      mask32_s = (32'd1 << (32'd1 << cfg_interrupt_msi_mmenable[2:0])) - 32'd1;
    end
  end

  assign mask_d = mask32_s[NV-1:0];

  // Round-robin pick: first eligible vector at or after (last grant + 1), or from 0 before any grant.
  always_comb begin
    logic [IRQ_INDEX_WIDTH-1:0] idx;
    idx     = {IRQ_INDEX_WIDTH{1'b0}};
    found_s = 1'b0;
    pick_s  = {IRQ_INDEX_WIDTH{1'b0}};
    if (granted_q) begin
      start_s = rr_q + IRQ_INDEX_WIDTH'(1);
    end else begin
      start_s = {IRQ_INDEX_WIDTH{1'b0}};
    end
    for (int i = 0; i < NV; i++) begin
      // Index arithmetic wraps naturally at the vector count.
      idx = start_s + IRQ_INDEX_WIDTH'(i);
      if (!found_s && eligible_s[idx]) begin
        found_s = 1'b1;
        pick_s  = idx;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic for the issue/wait(/backoff) sequencer and the pending bitmap.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    granted_d   = granted_q;
    msi_int_d   = 32'h0000_0000;
    stat_sent_d = 1'b0;
    stat_fail_d = 1'b0;
    do_issue_s  = 1'b0;
    set_s       = {NV{1'b0}};
    clr_s       = {NV{1'b0}};
`ifdef PCIE_MSI_FAIL_RETRY_EN
    cnt_d       = cnt_q;
`endif
    set_s[s_axis_irq_index] = accept_s;

    case (state_q)
      ST_IDLE: begin
        do_issue_s = issue_ok_s;
      end
      ST_WAIT: begin
        // sent wins when both responses arrive together
        if (cfg_interrupt_msi_sent) begin
          stat_sent_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (cfg_interrupt_msi_fail) begin
          stat_fail_d = 1'b1;
`ifdef PCIE_MSI_FAIL_RETRY_EN
          set_s[rr_q] = 1'b1;
          cnt_d       = RETRY_CNT_WIDTH'(RETRY_DELAY);
          state_d     = ST_BACKOFF;
`else
          state_d     = ST_IDLE;
`endif
        end else begin
          state_d = ST_WAIT;
        end
      end
`ifdef PCIE_MSI_FAIL_RETRY_EN
      ST_BACKOFF: begin
        // The last backoff cycle doubles as the arbitration cycle, so the
        // re-issue lands RETRY_DELAY+1 cycles after the fail response.
        if (cnt_q <= RETRY_CNT_WIDTH'(1)) begin
          if (issue_ok_s) begin
            do_issue_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - RETRY_CNT_WIDTH'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_issue_s) begin
      msi_int_d     = 32'd1 << pick_s;
      clr_s[pick_s] = 1'b1;
      rr_d          = pick_s;
      granted_d     = 1'b1;
      state_d       = ST_WAIT;
    end else begin
      msi_int_d = 32'h0000_0000;
    end

    // A set in the same cycle as the issue-clear wins, so a fresh MSI follows.
    pending_d = (pending_q & ~clr_s) | set_s;
  end

  // State, bitmap and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= {NV{1'b0}};
      mask_q      <= {NV{1'b0}};
      rr_q        <= {IRQ_INDEX_WIDTH{1'b0}};
      granted_q   <= 1'b0;
      msi_int_q   <= 32'h0000_0000;
      stat_sent_q <= 1'b0;
      stat_fail_q <= 1'b0;
      ready_q     <= 1'b0;
`ifdef PCIE_MSI_FAIL_RETRY_EN
      cnt_q       <= {RETRY_CNT_WIDTH{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      rr_q        <= rr_d;
      granted_q   <= granted_d;
      msi_int_q   <= msi_int_d;
      stat_sent_q <= stat_sent_d;
      stat_fail_q <= stat_fail_d;
      ready_q     <= 1'b1;
`ifdef PCIE_MSI_FAIL_RETRY_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign s_axis_irq_ready      = ready_q;
  assign cfg_interrupt_msi_int = msi_int_q;
  assign stat_irq_sent         = stat_sent_q;
  assign stat_irq_fail         = stat_fail_q;

  assign cfg_interrupt_msi_select                      = 4'h0;
  assign cfg_interrupt_msi_pending_status              = 32'h0000_0000;
  assign cfg_interrupt_msi_pending_status_data_enable  = 1'b0;
  assign cfg_interrupt_msi_pending_status_function_num = 4'h0;
  assign cfg_interrupt_msi_attr                        = 3'h0;
  assign cfg_interrupt_msi_tph_present                 = 1'b0;
  assign cfg_interrupt_msi_tph_type                    = 2'h0;
  assign cfg_interrupt_msi_tph_st_tag                  = 9'h000;
  assign cfg_interrupt_msi_function_number             = 4'h0;

endmodule

// File: tb/tb_pcie_msi_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pcie_msi_irq_ctrl
//
// Directed scenarios followed by randomized request bursts. Expected MSI order
// comes from a reference model: a 32-entry pending array, the last granted
// vector, and a modular search over the enabled vector range.
// -----------------------------------------------------------------------------
module tb_pcie_msi_irq_ctrl;

  localparam int IW  = 5;
  localparam int RD  = 64;
  localparam int RCW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] s_axis_irq_index;
  logic          s_axis_irq_valid;
  logic          s_axis_irq_ready;
  logic [3:0]    cfg_interrupt_msi_enable;
  logic [11:0]   cfg_interrupt_msi_mmenable;
  logic [31:0]   cfg_interrupt_msi_int;
  logic          cfg_interrupt_msi_sent;
  logic          cfg_interrupt_msi_fail;
  logic [3:0]    cfg_interrupt_msi_select;
  logic [31:0]   cfg_interrupt_msi_pending_status;
  logic          cfg_interrupt_msi_pending_status_data_enable;
  logic [3:0]    cfg_interrupt_msi_pending_status_function_num;
  logic [2:0]    cfg_interrupt_msi_attr;
  logic          cfg_interrupt_msi_tph_present;
  logic [1:0]    cfg_interrupt_msi_tph_type;
  logic [8:0]    cfg_interrupt_msi_tph_st_tag;
  logic [3:0]    cfg_interrupt_msi_function_number;
  logic          stat_irq_sent;
  logic          stat_irq_fail;

  always #2 clk = ~clk;

  pcie_msi_irq_ctrl #(
    .IRQ_INDEX_WIDTH(IW),
    .RETRY_DELAY    (RD),
    .RETRY_CNT_WIDTH(RCW)
  ) dut (
    .clk                                          (clk),
    .rst                                          (rst),
    .s_axis_irq_index                             (s_axis_irq_index),
    .s_axis_irq_valid                             (s_axis_irq_valid),
    .s_axis_irq_ready                             (s_axis_irq_ready),
    .cfg_interrupt_msi_enable                     (cfg_interrupt_msi_enable),
    .cfg_interrupt_msi_mmenable                   (cfg_interrupt_msi_mmenable),
    .cfg_interrupt_msi_int                        (cfg_interrupt_msi_int),
    .cfg_interrupt_msi_sent                       (cfg_interrupt_msi_sent),
    .cfg_interrupt_msi_fail                       (cfg_interrupt_msi_fail),
    .cfg_interrupt_msi_select                     (cfg_interrupt_msi_select),
    .cfg_interrupt_msi_pending_status             (cfg_interrupt_msi_pending_status),
    .cfg_interrupt_msi_pending_status_data_enable (cfg_interrupt_msi_pending_status_data_enable),
    .cfg_interrupt_msi_pending_status_function_num(cfg_interrupt_msi_pending_status_function_num),
    .cfg_interrupt_msi_attr                       (cfg_interrupt_msi_attr),
    .cfg_interrupt_msi_tph_present                (cfg_interrupt_msi_tph_present),
    .cfg_interrupt_msi_tph_type                   (cfg_interrupt_msi_tph_type),
    .cfg_interrupt_msi_tph_st_tag                 (cfg_interrupt_msi_tph_st_tag),
    .cfg_interrupt_msi_function_number            (cfg_interrupt_msi_function_number),
    .stat_irq_sent                                (stat_irq_sent),
    .stat_irq_fail                                (stat_irq_fail)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit pend[32];
  int last_grant = -1;
  int mm_m = 5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_next();
    int n;
    int start;
    int v;
    n = (mm_m >= 5) ? 32 : (1 << mm_m);
    start = (last_grant < 0) ? 0 : (last_grant + 1) % 32;
    for (int k = 0; k < 32; k++) begin
      v = (start + k) % 32;
      if (pend[v] && v < n) return v;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    last_grant = -1;
  endtask

  task automatic set_mm(input int m);
    cfg_interrupt_msi_mmenable = 12'(m);
    mm_m = m;
  endtask

  task automatic req(input int idx);
    s_axis_irq_index = IW'(idx);
    s_axis_irq_valid = 1'b1;
    check("req_ready", {31'h0, s_axis_irq_ready}, 32'h1);
    tick();
    s_axis_irq_valid = 1'b0;
    pend[idx] = 1'b1;
  endtask

  task automatic wait_msi(input string tag, input int exp_v);
    logic [31:0] expv;
    for (int i = 0; i < 8; i++) begin
      if (cfg_interrupt_msi_int != 32'h0) break;
      tick();
    end
    expv = (exp_v < 0) ? 32'h0 : (32'h1 << exp_v);
    check(tag, cfg_interrupt_msi_int, expv);
    if (exp_v >= 0) begin
      pend[exp_v] = 1'b0;
      last_grant = exp_v;
      tick();
      check({tag, "_pulse"}, cfg_interrupt_msi_int, 32'h0);
    end
  endtask

  task automatic send_sent();
    cfg_interrupt_msi_sent = 1'b1;
    tick();
    cfg_interrupt_msi_sent = 1'b0;
    check("stat_sent", {30'h0, stat_irq_sent, stat_irq_fail}, 32'h2);
    tick();
    check("stat_sent_end", {31'h0, stat_irq_sent}, 32'h0);
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (cfg_interrupt_msi_int != 32'h0) seen = 1'b1;
      tick();
    end
    check(tag, {31'h0, seen}, 32'h0);
  endtask

  // Watchdog so a stuck run still ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int v;
    int cnt;
    rst = 1'b1;
    s_axis_irq_index = '0;
    s_axis_irq_valid = 1'b0;
    cfg_interrupt_msi_enable = 4'h1;
    cfg_interrupt_msi_mmenable = 12'd5;
    cfg_interrupt_msi_sent = 1'b0;
    cfg_interrupt_msi_fail = 1'b0;
    model_reset();

    // Reset state
    repeat (3) tick();
    check("rst_ready", {31'h0, s_axis_irq_ready}, 32'h0);
    check("rst_msi", cfg_interrupt_msi_int, 32'h0);
    check("rst_stat", {30'h0, stat_irq_sent, stat_irq_fail}, 32'h0);
    check("tie_a", cfg_interrupt_msi_pending_status, 32'h0);
    check("tie_b", {4'h0, cfg_interrupt_msi_select, cfg_interrupt_msi_pending_status_data_enable,
                    cfg_interrupt_msi_pending_status_function_num, cfg_interrupt_msi_attr,
                    cfg_interrupt_msi_tph_present, cfg_interrupt_msi_tph_type,
                    cfg_interrupt_msi_function_number}, 32'h0);
    check("tie_c", {23'h0, cfg_interrupt_msi_tph_st_tag}, 32'h0);
    rst = 1'b0;
    check("ready_at_release", {31'h0, s_axis_irq_ready}, 32'h0);
    tick();
    check("ready_after_release", {31'h0, s_axis_irq_ready}, 32'h1);

    // Single request, two-cycle latency
    req(3);
    check("lat_n1", cfg_interrupt_msi_int, 32'h0);
    tick();
    check("lat_n2", cfg_interrupt_msi_int, 32'h8);
    pend[3] = 1'b0; last_grant = 3;
    tick();
    check("lat_pulse", cfg_interrupt_msi_int, 32'h0);
    tick(); tick();
    send_sent();
    quiet("idle_after_3", 4);

    // Round-robin: 0 in flight, then 7,2,7 queued -> 2 then 7
    req(0);
    wait_msi("rr_0", 0);
    req(7); req(2); req(7);
    send_sent();
    wait_msi("rr_2", 2);
    send_sent();
    wait_msi("rr_7", 7);
    send_sent();
    quiet("rr_no_third", 8);

    // Vector beyond enabled range waits for mmenable to grow
    set_mm(1);
    tick(); tick();
    req(5);
    quiet("mm_masked", 6);
    set_mm(3);
    tick();
    check("mm_grow_n1", cfg_interrupt_msi_int, 32'h0);
    tick();
    check("mm_grow_n2", cfg_interrupt_msi_int, 32'h20);
    pend[5] = 1'b0; last_grant = 5;
    tick();
    check("mm_grow_pulse", cfg_interrupt_msi_int, 32'h0);
    send_sent();
    set_mm(5);
    tick(); tick();

    // Disabled MSI accumulates requests
    cfg_interrupt_msi_enable = 4'h0;
    req(1); req(4);
    quiet("disabled", 6);
    cfg_interrupt_msi_enable = 4'h1;
    wait_msi("en_1", 1);
    send_sent();
    wait_msi("en_4", 4);
    send_sent();
    quiet("en_done", 6);

    // Fail on vector 6
    req(6);
    wait_msi("fail_issue", 6);
    cfg_interrupt_msi_fail = 1'b1;
    tick();
    cfg_interrupt_msi_fail = 1'b0;
    check("stat_fail", {30'h0, stat_irq_sent, stat_irq_fail}, 32'h1);
`ifdef PCIE_MSI_FAIL_RETRY_EN
    pend[6] = 1'b1;
    k = 1;
    while (cfg_interrupt_msi_int == 32'h0 && k < 200) begin
      if (k == 10) begin
        s_axis_irq_index = IW'(6);
        s_axis_irq_valid = 1'b1;
      end else begin
        s_axis_irq_valid = 1'b0;
      end
      tick();
      k++;
    end
    s_axis_irq_valid = 1'b0;
    check("retry_delay", 32'(k), 32'(RD + 1));
    check("retry_vec", cfg_interrupt_msi_int, 32'h40);
    pend[6] = 1'b0; last_grant = 6;
    tick();
    check("retry_pulse", cfg_interrupt_msi_int, 32'h0);
    send_sent();
    quiet("retry_single", 10);
`else
    quiet("no_retry", 80);
`endif

    // sent and fail together count as sent
    req(13);
    wait_msi("both_issue", 13);
    cfg_interrupt_msi_sent = 1'b1;
    cfg_interrupt_msi_fail = 1'b1;
    tick();
    cfg_interrupt_msi_sent = 1'b0;
    cfg_interrupt_msi_fail = 1'b0;
    check("both_stat", {30'h0, stat_irq_sent, stat_irq_fail}, 32'h2);
    quiet("both_no_reissue", 80);

    // Request arriving on the issue-clear cycle produces a fresh MSI
    s_axis_irq_index = IW'(9);
    s_axis_irq_valid = 1'b1;
    tick();
    check("setwins_n1", cfg_interrupt_msi_int, 32'h0);
    tick();
    s_axis_irq_valid = 1'b0;
    check("setwins_first", cfg_interrupt_msi_int, 32'h200);
    last_grant = 9; pend[9] = 1'b1;
    tick();
    send_sent();
    wait_msi("setwins_again", 9);
    send_sent();
    quiet("setwins_done", 6);

    // Reset during WAIT discards everything
    req(10);
    wait_msi("rst_issue", 10);
    req(11); req(12);
    #1 rst = 1'b1;
    #1;
    check("midrst_ready", {31'h0, s_axis_irq_ready}, 32'h0);
    check("midrst_msi", cfg_interrupt_msi_int, 32'h0);
    tick(); tick();
    rst = 1'b0;
    model_reset();
    cfg_interrupt_msi_sent = 1'b1;
    tick();
    cfg_interrupt_msi_sent = 1'b0;
    check("late_sent_ignored", {30'h0, stat_irq_sent, stat_irq_fail}, 32'h0);
    check("midrst_ready_after", {31'h0, s_axis_irq_ready}, 32'h1);
    quiet("midrst_bitmap_clear", 8);

    // No prior grant: lowest index first
    cfg_interrupt_msi_enable = 4'h0;
    req(5); req(2);
    cfg_interrupt_msi_enable = 4'h1;
    wait_msi("low_first", 2);
    send_sent();
    wait_msi("low_second", 5);
    send_sent();
    quiet("low_done", 6);

    // Randomized bursts checked against the model
    for (int r = 0; r < 24; r++) begin
      cfg_interrupt_msi_enable = 4'h0;
      set_mm($urandom_range(0, 7));
      tick(); tick();
      cnt = $urandom_range(1, 6);
      for (int j = 0; j < cnt; j++) req($urandom_range(0, 31));
      cfg_interrupt_msi_enable = 4'h1;
      for (int s = 0; s < 40; s++) begin
        v = model_next();
        if (v < 0) break;
        wait_msi("rnd_vec", v);
        if ($urandom_range(0, 1) == 1) req($urandom_range(0, 31));
        send_sent();
      end
      quiet("rnd_quiet", 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
